// File: rtl/ball_move_ctrl.sv
// rtl/ball_move_ctrl.sv - frame-synchronous ball motion controller (optional BALL_AUTO_BOUNCE_EN)
module ball_move_ctrl #(
  parameter int H_VALID    = 640,
  parameter int V_VALID    = 480,
  parameter int BALL_SIZE  = 16,
  parameter int STEP       = 2,
  parameter int DEB_FRAMES = 3
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       move_done
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_MOVE_X = 2'd2;
  localparam logic [1:0] S_MOVE_Y = 2'd3;

  localparam logic [9:0]  X_MAX  = 10'(H_VALID - BALL_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_VALID - BALL_SIZE);
  localparam logic [9:0]  X_RST  = 10'((H_VALID - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_RST  = 10'((V_VALID - BALL_SIZE) / 2);
  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [3:0]  DEB_N  = 4'(DEB_FRAMES);

  // Button bit order throughout: {up, down, left, right}
  logic [1:0]      state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0]      qual_q, qual_d;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]      x_dec, x_inc, y_dec, y_inc;
  logic            move_done_q, move_done_d;
  logic            frame_end;
`ifdef BALL_AUTO_BOUNCE_EN
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
`endif

  function automatic logic [9:0] sat_dec(input logic [9:0] v);
    return (v < STEP10) ? 10'd0 : v - STEP10;
  endfunction

  // Sum is formed in 11 bits so a coordinate near 1023 cannot wrap before the clamp
  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, v} + STEP11;
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

  assign frame_end = (state_q == S_WAIT) &&
                     (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

  assign x_dec = sat_dec(ball_x_q);
  assign x_inc = sat_inc(ball_x_q, X_MAX);
  assign y_dec = sat_dec(ball_y_q);
  assign y_inc = sat_inc(ball_y_q, Y_MAX);

  // Sequencer: one sample/move-x/move-y pass per frame, started at the last visible pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (frame_end) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_MOVE_X;
      S_MOVE_X: state_d = S_MOVE_Y;
      default:  state_d = S_WAIT;
    endcase
  end

  // Per-button debounce counters saturate at DEB_FRAMES and clear on any released sample
  always_comb begin
    cnt_d  = cnt_q;
    qual_d = qual_q;
    if (state_q == S_SAMPLE) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i]) cnt_d[i] = (cnt_q[i] >= DEB_N) ? DEB_N : cnt_q[i] + 4'd1;
        else            cnt_d[i] = 4'd0;
        qual_d[i] = (cnt_d[i] == DEB_N);
      end
    end
  end

  // Axis update: opposing buttons cancel, a lone qualified button steps with clamping
  always_comb begin
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    move_done_d = (state_q == S_MOVE_Y);
`ifdef BALL_AUTO_BOUNCE_EN
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
`endif
    if (state_q == S_MOVE_X) begin
      case ({qual_q[1], qual_q[0]})
        2'b10: begin
          ball_x_d = x_dec;
`ifdef BALL_AUTO_BOUNCE_EN
          dir_x_d  = 1'b0;
`endif
        end
        2'b01: begin
          ball_x_d = x_inc;
`ifdef BALL_AUTO_BOUNCE_EN
          dir_x_d  = 1'b1;
`endif
        end
`ifdef BALL_AUTO_BOUNCE_EN
        2'b00: begin
          if (dir_x_q) begin
            ball_x_d = x_inc;
            if (x_inc == X_MAX) dir_x_d = 1'b0;
          end else begin
            ball_x_d = x_dec;
            if (x_dec == 10'd0) dir_x_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    if (state_q == S_MOVE_Y) begin
      case ({qual_q[3], qual_q[2]})
        2'b10: begin
          ball_y_d = y_dec;
`ifdef BALL_AUTO_BOUNCE_EN
          dir_y_d  = 1'b0;
`endif
        end
        2'b01: begin
          ball_y_d = y_inc;
`ifdef BALL_AUTO_BOUNCE_EN
          dir_y_d  = 1'b1;
`endif
        end
`ifdef BALL_AUTO_BOUNCE_EN
        2'b00: begin
          if (dir_y_q) begin
            ball_y_d = y_inc;
            if (y_inc == Y_MAX) dir_y_d = 1'b0;
          end else begin
            ball_y_d = y_dec;
            if (y_dec == 10'd0) dir_y_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State, synchronizers, debounce and position registers; reset aborts any update in flight
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_WAIT;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      qual_q      <= '0;
      ball_x_q    <= X_RST;
      ball_y_q    <= Y_RST;
      move_done_q <= 1'b0;
`ifdef BALL_AUTO_BOUNCE_EN
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= {up, down, left, right};
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      qual_q      <= qual_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      move_done_q <= move_done_d;
`ifdef BALL_AUTO_BOUNCE_EN
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
`endif
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign move_done = move_done_q;

endmodule

// File: tb/tb_ball_move_ctrl.sv
// tb/tb_ball_move_ctrl.sv - self-checking bench for ball_move_ctrl
module tb_ball_move_ctrl;

  logic       vga_clk = 1'b0;
  logic       sys_rst_n;
  logic [9:0] pix_x, pix_y;
  logic       up, down, left, right;
  logic [9:0] ball_x, ball_y;
  logic       move_done;

  int checks   = 0;
  int failures = 0;

  // Reference state: per-button consecutive-press counts and ball position
  int mcnt [4];
  int mx, my;

  typedef struct {
    logic [3:0] btn;
    int         frames;
    int         ex;
    int         ey;
  } vec_t;

  vec_t tbl [11];

  ball_move_ctrl dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .move_done (move_done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    mx = 312;
    my = 232;
  endtask

  // One frame of the reference: debounce, then move each axis with clamping to 0..max
  task automatic model_frame(input logic [3:0] b);
    bit q [4];
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = b[i] ? ((mcnt[i] + 1 > 3) ? 3 : mcnt[i] + 1) : 0;
      q[i]    = (mcnt[i] == 3);
    end
    if (q[1] && !q[0])      mx = (mx - 2 < 0)   ? 0   : mx - 2;
    else if (q[0] && !q[1]) mx = (mx + 2 > 624) ? 624 : mx + 2;
    if (q[3] && !q[2])      my = (my - 2 < 0)   ? 0   : my - 2;
    else if (q[2] && !q[3]) my = (my + 2 > 464) ? 464 : my + 2;
  endtask

  // Drive one compressed frame and check the commit timing cycle by cycle
  task automatic run_frame(input logic [3:0] b);
    int old_y;
    {up, down, left, right} = b;
    pix_x = 10'd0;
    pix_y = 10'd0;
    repeat (4) tick();
    old_y = my;
    model_frame(b);
    pix_x = 10'd639;
    pix_y = 10'd479;
    tick();
    pix_x = 10'd0;
    pix_y = 10'd0;
    check("md_t1", move_done, 0);
    tick();
    check("md_t2", move_done, 0);
    tick();
    check("x_t3", ball_x, mx);
    check("y_t3_old", ball_y, old_y);
    check("md_t3", move_done, 0);
    tick();
    check("y_t4", ball_y, my);
    check("md_t4", move_done, 1);
    tick();
    check("md_t5", move_done, 0);
  endtask

  initial begin
    int         pulses;
    logic [3:0] rb;

    tbl[0]  = '{4'b0000,   3, 312, 232};
    tbl[1]  = '{4'b0001,   1, 312, 232};
    tbl[2]  = '{4'b0001,   1, 312, 232};
    tbl[3]  = '{4'b0001,   1, 314, 232};
    tbl[4]  = '{4'b0001,   1, 316, 232};
    tbl[5]  = '{4'b0000,   1, 316, 232};
    tbl[6]  = '{4'b0001,   2, 316, 232};
    tbl[7]  = '{4'b0000,   1, 316, 232};
    tbl[8]  = '{4'b0100, 120, 316, 464};
    tbl[9]  = '{4'b1100,   5, 316, 464};
    tbl[10] = '{4'b0010, 200,   0, 464};

    sys_rst_n = 1'b0;
    {up, down, left, right} = 4'b0000;
    pix_x = 10'd0;
    pix_y = 10'd0;
    model_reset();
    repeat (3) tick();
    check("rst_x", ball_x, 312);
    check("rst_y", ball_y, 232);
    check("rst_md", move_done, 0);
    sys_rst_n = 1'b1;
    tick();

    for (int r = 0; r < 11; r++) begin
      for (int f = 0; f < tbl[r].frames; f++) run_frame(tbl[r].btn);
      check($sformatf("tbl%0d_x", r), ball_x, tbl[r].ex);
      check($sformatf("tbl%0d_y", r), ball_y, tbl[r].ey);
    end

    // Coordinates outside the visible area must never start an update
    {up, down, left, right} = 4'b0001;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      pix_x = (c < 20) ? 10'h3FF : 10'd639;
      pix_y = 10'h3FF;
      tick();
      if (move_done) pulses++;
    end
    check("inv_pulses", pulses, 0);
    check("inv_x", ball_x, 0);
    {up, down, left, right} = 4'b0000;
    pix_x = 10'd0;
    pix_y = 10'd0;
    repeat (4) tick();

    // Reset asserted while the FSM sits in S_MOVE_X
    {up, down, left, right} = 4'b0001;
    repeat (4) tick();
    pix_x = 10'd639;
    pix_y = 10'd479;
    tick();
    pix_x = 10'd0;
    pix_y = 10'd0;
    tick();
    sys_rst_n = 1'b0;
    #1;
    check("midrst_x", ball_x, 312);
    check("midrst_y", ball_y, 232);
    check("midrst_md", move_done, 0);
    {up, down, left, right} = 4'b0000;
    tick();
    tick();
    check("midrst_hold_x", ball_x, 312);
    check("midrst_hold_md", move_done, 0);
    sys_rst_n = 1'b1;
    model_reset();
    tick();
    run_frame(4'b0000);
    check("post_rst_x", ball_x, 312);
    check("post_rst_y", ball_y, 232);

    // Randomized button histories against the reference
    rb = 4'b0000;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom);
      run_frame(rb);
    end
    check("rand_x", ball_x, mx);
    check("rand_y", ball_y, my);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
